hazard_unit: RTL and testbench

HAZARD_UNIT -- requirements
Module: hazard_unit

---
 rtl/hazard_unit.sv | 101 ++++++++++
 tb/tb_hazard_unit.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_unit.sv
// Stall/forward decision for D against a Tnew shadow pipeline, plus HI/LO busy tracking.
// Outputs are combinational (0 cycles) from D inputs and registered state; stall freezes F/D and bubbles E.
module hazard_unit #(
  parameter int NSTAGE   = 3,
  parameter int TW       = 3,
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10,
  parameter int CW       = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [4:0]                       D_rs,
  input  logic [4:0]                       D_rt,
  input  logic [TW-1:0]                    D_tuse_rs,
  input  logic [TW-1:0]                    D_tuse_rt,
  input  logic [4:0]                       D_wa,
  input  logic [TW-1:0]                    D_tnew,
  input  logic                             D_md_start,
  input  logic                             D_md_div,
  input  logic                             D_hl_use,
  input  logic                             flush,
  output logic                             stall,
  output logic                             md_busy,
  output logic [$clog2(NSTAGE+1)-1:0]      fwd_rs_sel,
  output logic [$clog2(NSTAGE+1)-1:0]      fwd_rt_sel
);

  localparam int SW = $clog2(NSTAGE + 1);

  logic [4:0]    r_wa   [1:NSTAGE];
  logic [TW-1:0] r_tnew [1:NSTAGE];
  logic [CW-1:0] r_md_cnt;

  logic          w_rs_hit, w_rt_hit;
  logic [TW-1:0] w_rs_tnew, w_rt_tnew;
  logic [SW-1:0] w_rs_sel, w_rt_sel;
  logic          w_stall_rs, w_stall_rt, w_stall_hl;

  // Scan oldest to youngest so the youngest match is the one that sticks.
  always_comb begin
    w_rs_hit  = 1'b0;
    w_rt_hit  = 1'b0;
    w_rs_tnew = '0;
    w_rt_tnew = '0;
    w_rs_sel  = '0;
    w_rt_sel  = '0;
    for (int k = NSTAGE; k >= 1; k--) begin
      if (D_rs != 5'd0 && r_wa[k] == D_rs) begin
        w_rs_hit  = 1'b1;
        w_rs_tnew = r_tnew[k];
        w_rs_sel  = SW'(k);
      end
      if (D_rt != 5'd0 && r_wa[k] == D_rt) begin
        w_rt_hit  = 1'b1;
        w_rt_tnew = r_tnew[k];
        w_rt_sel  = SW'(k);
      end
    end
  end

  assign w_stall_rs = w_rs_hit && (D_tuse_rs < w_rs_tnew);
  assign w_stall_rt = w_rt_hit && (D_tuse_rt < w_rt_tnew);
  assign md_busy    = (r_md_cnt != '0);
  assign w_stall_hl = D_hl_use & md_busy;
  assign stall      = w_stall_rs | w_stall_rt | w_stall_hl;
  assign fwd_rs_sel = w_rs_sel;
  assign fwd_rt_sel = w_rt_sel;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 1; k <= NSTAGE; k++) begin
        r_wa[k]   <= '0;
        r_tnew[k] <= '0;
      end
    end else if (flush) begin
      for (int k = 1; k <= NSTAGE; k++) begin
        r_wa[k]   <= '0;
        r_tnew[k] <= '0;
      end
    end else begin
      r_wa[1]   <= stall ? 5'd0 : D_wa;
      r_tnew[1] <= stall ? '0 : D_tnew;
      for (int k = 2; k <= NSTAGE; k++) begin
        r_wa[k]   <= r_wa[k-1];
        r_tnew[k] <= (r_tnew[k-1] == '0) ? '0 : r_tnew[k-1] - TW'(1);
      end
    end
  end

  // A stalled md_start never reaches E, so a busy unit cannot be restarted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_md_cnt <= '0;
    end else if (D_md_start && !stall && !flush) begin
      r_md_cnt <= D_md_div ? CW'(DIV_CYC) : CW'(MULT_CYC);
    end else if (r_md_cnt != '0) begin
      r_md_cnt <= r_md_cnt - CW'(1);
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench: each row pushes its expected {stall, md_busy, fwd_rs, fwd_rt} when driven.
module tb_hazard_unit;

  logic       clk;
  logic       reset;
  logic [4:0] D_rs, D_rt, D_wa;
  logic [2:0] D_tuse_rs, D_tuse_rt, D_tnew;
  logic       D_md_start, D_md_div, D_hl_use, flush;
  logic       stall, md_busy;
  logic [1:0] fwd_rs_sel, fwd_rt_sel;

  hazard_unit dut (
    .clk(clk), .reset(reset),
    .D_rs(D_rs), .D_rt(D_rt), .D_tuse_rs(D_tuse_rs), .D_tuse_rt(D_tuse_rt),
    .D_wa(D_wa), .D_tnew(D_tnew), .D_md_start(D_md_start), .D_md_div(D_md_div),
    .D_hl_use(D_hl_use), .flush(flush),
    .stall(stall), .md_busy(md_busy), .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] rs, rt, wa;
    logic [2:0] trs, trt, tnew;
    logic       start, div, hl, fl;
    logic [5:0] exp;
  } row_t;

  logic [5:0] sb[$];
  int checks = 0;
  int errors = 0;

  function automatic row_t mk(input int rs, input int trs, input int rt, input int trt,
                              input int wa, input int tnew, input int start, input int div,
                              input int hl, input int fl, input logic [5:0] exp);
    row_t r;
    r.rs = 5'(rs);  r.trs = 3'(trs); r.rt = 5'(rt); r.trt = 3'(trt);
    r.wa = 5'(wa);  r.tnew = 3'(tnew);
    r.start = 1'(start); r.div = 1'(div); r.hl = 1'(hl); r.fl = 1'(fl);
    r.exp = exp;
    return r;
  endfunction

  function automatic logic [5:0] obs();
    return {stall, md_busy, fwd_rs_sel, fwd_rt_sel};
  endfunction

  task automatic drive_row(input row_t r);
    D_rs = r.rs; D_tuse_rs = r.trs; D_rt = r.rt; D_tuse_rt = r.trt;
    D_wa = r.wa; D_tnew = r.tnew; D_md_start = r.start; D_md_div = r.div;
    D_hl_use = r.hl; flush = r.fl;
    sb.push_back(r.exp);
  endtask

  task automatic idle(input int n);
    D_rs = 0; D_tuse_rs = 0; D_rt = 0; D_tuse_rt = 0; D_wa = 0; D_tnew = 0;
    D_md_start = 0; D_md_div = 0; D_hl_use = 0; flush = 0;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    row_t rows[$];
    logic [5:0] e, got;
    rows.push_back(mk(5, 0, 5, 0, 5, 3, 1, 1, 1, 0, 6'b0_0_00_00));
    rows.push_back(mk(5, 0, 5, 0, 5, 3, 1, 1, 1, 0, 6'b0_0_00_00));
    foreach (rows[i]) begin
      drive_row(rows[i]);
      #2;
      got = obs(); e = sb.pop_front(); checks++;
      if (got !== e) begin errors++; $display("FAIL reset[%0d] got %b want %b", i, got, e); end
      @(negedge clk);
    end
    idle(0);
    reset = 1'b1;
    idle(2);
  endtask

  task automatic test_load_use();
    row_t rows[$];
    logic [5:0] e, got;
    rows.push_back(mk(0, 0, 0, 0, 5, 2, 0, 0, 0, 0, 6'b0_0_00_00));
    rows.push_back(mk(5, 1, 5, 2, 0, 0, 0, 0, 0, 0, 6'b1_0_01_01));
    rows.push_back(mk(5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 6'b0_0_10_00));
    rows.push_back(mk(5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 6'b0_0_11_00));
    rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b0_0_00_00));
    foreach (rows[i]) begin
      drive_row(rows[i]);
      #2;
      got = obs(); e = sb.pop_front(); checks++;
      if (got !== e) begin errors++; $display("FAIL load_use[%0d] got %b want %b", i, got, e); end
      @(negedge clk);
    end
    idle(3);
  endtask

  task automatic test_zero_reg();
    row_t rows[$];
    logic [5:0] e, got;
    rows.push_back(mk(0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 6'b0_0_00_00));
    rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b0_0_00_00));
    foreach (rows[i]) begin
      drive_row(rows[i]);
      #2;
      got = obs(); e = sb.pop_front(); checks++;
      if (got !== e) begin errors++; $display("FAIL zero_reg[%0d] got %b want %b", i, got, e); end
      @(negedge clk);
    end
    idle(3);
  endtask

  task automatic test_youngest();
    row_t rows[$];
    logic [5:0] e, got;
    rows.push_back(mk(0, 0, 0, 0, 3, 2, 0, 0, 0, 0, 6'b0_0_00_00));
    rows.push_back(mk(0, 0, 0, 0, 3, 0, 0, 0, 0, 0, 6'b0_0_00_00));
    rows.push_back(mk(3, 0, 3, 0, 0, 0, 0, 0, 0, 0, 6'b0_0_01_01));
    rows.push_back(mk(3, 0, 3, 0, 0, 0, 0, 0, 0, 0, 6'b0_0_10_10));
    foreach (rows[i]) begin
      drive_row(rows[i]);
      #2;
      got = obs(); e = sb.pop_front(); checks++;
      if (got !== e) begin errors++; $display("FAIL youngest[%0d] got %b want %b", i, got, e); end
      @(negedge clk);
    end
    idle(3);
  endtask

  task automatic test_flush();
    row_t rows[$];
    logic [5:0] e, got;
    rows.push_back(mk(0, 0, 0, 0, 7, 2, 0, 0, 0, 0, 6'b0_0_00_00));
    rows.push_back(mk(7, 0, 0, 0, 7, 2, 0, 0, 0, 1, 6'b1_0_01_00));
    rows.push_back(mk(7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b0_0_00_00));
    foreach (rows[i]) begin
      drive_row(rows[i]);
      #2;
      got = obs(); e = sb.pop_front(); checks++;
      if (got !== e) begin errors++; $display("FAIL flush[%0d] got %b want %b", i, got, e); end
      @(negedge clk);
    end
    idle(3);
  endtask

  // Mult with a stalled second mult retrying in D, then a div.
  task automatic test_md_busy();
    row_t rows[$];
    logic [5:0] e, got;
    rows.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 6'b0_0_00_00));
    for (int c = 0; c < 5; c++) rows.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 6'b1_1_00_00));
    rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 6'b0_0_00_00));
    rows.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 6'b0_0_00_00));
    for (int c = 0; c < 10; c++) rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 6'b1_1_00_00));
    rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 6'b0_0_00_00));
    foreach (rows[i]) begin
      drive_row(rows[i]);
      #2;
      got = obs(); e = sb.pop_front(); checks++;
      if (got !== e) begin errors++; $display("FAIL md_busy[%0d] got %b want %b", i, got, e); end
      @(negedge clk);
    end
    idle(3);
  endtask

  task automatic test_reset_mid_div();
    row_t rows[$];
    logic [5:0] e, got;
    rows.push_back(mk(0, 0, 0, 0, 5, 1, 1, 1, 0, 0, 6'b0_0_00_00));
    rows.push_back(mk(0, 0, 0, 0, 6, 1, 0, 0, 0, 0, 6'b0_1_00_00));
    rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b0_1_00_00));
    rows.push_back(mk(6, 0, 5, 0, 0, 0, 0, 0, 0, 0, 6'b0_1_10_11));
    foreach (rows[i]) begin
      drive_row(rows[i]);
      #2;
      got = obs(); e = sb.pop_front(); checks++;
      if (got !== e) begin errors++; $display("FAIL mid_div[%0d] got %b want %b", i, got, e); end
      @(negedge clk);
    end
    drive_row(mk(6, 0, 5, 0, 0, 0, 0, 0, 1, 0, 6'b1_1_11_00));
    #2;
    got = obs(); e = sb.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL mid_div_pre got %b want %b", got, e); end
    #1;
    reset = 1'b0;
    sb.push_back(6'b0_0_00_00);
    #1;
    got = obs(); e = sb.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL mid_div_async got %b want %b", got, e); end
    @(negedge clk);
    sb.push_back(6'b0_0_00_00);
    #2;
    got = obs(); e = sb.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL mid_div_held got %b want %b", got, e); end
    idle(0);
    reset = 1'b1;
    idle(2);
  endtask

  initial begin
    reset = 1'b0;
    D_rs = 0; D_tuse_rs = 0; D_rt = 0; D_tuse_rt = 0; D_wa = 0; D_tnew = 0;
    D_md_start = 0; D_md_div = 0; D_hl_use = 0; flush = 0;
    #1;
    test_reset();
    test_load_use();
    test_zero_reg();
    test_youngest();
    test_flush();
    test_md_busy();
    test_reset_mid_div();
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain left %0d want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
